writeback_unit: RTL and testbench
=================================

# writeback_unit

Writeback stage feeding the 32x32 register file. It merges single-cycle ALU results with variable-latency load results, buffers loads that collide with ALU writes, and drives the register file write port (`rf_rw`, `rf_bus_w`, `rf_we`) from registered outputs. It keeps a pending-load scoreboard so decode can stall on RAW/WAW hazards, and can optionally bypass the in-flight write onto the operand buses.

## Interface
Parameters:
- `DEPTH`, 2: load buffer entries (power of 2, at least 2).
- `STARVE_MAX`, 4: consecutive ALU-priority cycles with a non-empty buffer before the ALU is stalled.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `alu_valid`  in  1  ALU result present this cycle.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `alu_stall`  out  1  registered; while high, upstream must hold `alu_valid` low.
- `ld_valid`  in  1  load result offered.
- `ld_ready`  out  1  registered; load result accepted when `ld_valid` and `ld_ready` are both high.
- `ld_rd`  in  5  load destination register.
- `ld_data`  in  32  load data.
- `pend_set`  in  1  decode issued a load.
- `pend_rd`  in  5  destination register of the issued load.
- `busy_mask`  out  32  registered; bit n high means a load to register n is outstanding.
- `rf_rw`  out  5  register file write address (registered).
- `rf_bus_w`  out  32  register file write data (registered).
- `rf_we`  out  1  register file write enable (registered).
- `ra`, `rb`  in  5  decode read addresses.
- `rf_bus_a`, `rf_bus_b`  in  32  register file read data.
- `opnd_a`, `opnd_b`  out  32  operands to execute (combinational).

## Operation
- Commit: at most one register file write per cycle.
- Priority order:
  1. Forced drain: `alu_stall` is high and the buffer is non-empty.
  2. `alu_valid`.
  3. Buffer head.
  4. Direct load: buffer empty and a load is accepted this cycle; no buffer entry is written.
- Load with ALU priority: an accepted load is pushed into the buffer when an ALU write or a non-empty buffer takes priority that cycle.
- `ld_ready` is high when the buffer has at least one free slot after this cycle's push and pop.
- Register 0: any write to register 0 is dropped, so `rf_we` stays low. `busy_mask[0]` is never set.
- Scoreboard:
  - `pend_set` sets `busy_mask[pend_rd]`.
  - A load commit clears the bit for its `rd`.
  - If a set and a clear hit the same register in one cycle, the set wins.
  - ALU commits never clear bits.
- Precondition, asserted by the bench: decode never issues a write to a register whose busy bit is set.
- Starvation counter:
  - Increments each cycle the buffer is non-empty and an ALU write wins.
  - Resets to 0 whenever the buffer pops or is empty.
  - Reaching `STARVE_MAX` sets `alu_stall` for the next cycle.
  - `alu_stall` clears once one entry has drained.
- `alu_valid` is ignored while `alu_stall` is high. This is a protocol violation and the bench flags it.
- Buffer ordering is FIFO; wrap-around uses `log2(DEPTH)`-bit pointers plus a count.

## Timing
- Reset values (while `rst` is low at an edge):
  - `rf_we`, `rf_rw`, `rf_bus_w` = 0.
  - `busy_mask` = 0.
  - `alu_stall` = 0.
  - `ld_ready` = 0.
  - Buffer empty; counter 0.
- After reset: `ld_ready` goes high on the first edge with `rst` high.
- Latency:
  - ALU result presented in cycle N: `rf_we` high in cycle N+1.
  - Direct load: same N+1 latency.
  - Buffered load: commits the cycle after it becomes the highest-priority source.
- Mid-operation reset: buffered loads are discarded and the scoreboard is cleared. Upstream must reissue.
- Full buffer with an ALU write pending: `ld_ready` is low; no load is lost.

## Configuration
- `WB_FORWARD_EN` defined:
  - `opnd_a` = `rf_bus_w` when `rf_we` is high and `rf_rw == ra` and `ra != 0`; otherwise `rf_bus_a`.
  - `opnd_b` uses the same rule with `rb` and `rf_bus_b`.
- Undefined: `opnd_a` = `rf_bus_a` and `opnd_b` = `rf_bus_b`. Decode must then stall one cycle on a match.

## Test plan
- ALU only: `alu_valid` with `rd=5`, `data=0xDEADBEEF` in cycle N -> cycle N+1 shows `rf_we=1`, `rf_rw=5`, `rf_bus_w=0xDEADBEEF`.
- Collision: ALU (`rd=3`, `0x11`) and load (`rd=7`, `0x22`) in the same cycle -> ALU commits at N+1, load commits at N+2, `busy_mask[7]` clears at N+3.
- Backpressure, `DEPTH=2`: ALU valid continuously while 3 loads are offered -> `ld_ready` drops after 2 loads are accepted. After 4 ALU-priority cycles, `alu_stall=1` and the first load drains; no data is lost and load order is preserved.
- Register 0: ALU `rd=0` and load `rd=0` -> `rf_we` never asserts; `busy_mask` stays 0.
- Scoreboard: `pend_set` with `rd=9`, then the load completes -> `busy_mask[9]` is high from set+1 until the load commit.
- Reset mid-flight: 2 buffered loads, then `rst=0` for one cycle -> outputs all 0 and the buffer is empty. With `WB_FORWARD_EN`, `ra=5` during the rd=5 commit gives `opnd_a=0xDEADBEEF`.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU and load results onto the register-file write port,
// buffers colliding loads and tracks pending loads. Define WB_FORWARD_EN to bypass operands.
module writeback_unit #(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_stall,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [4:0]  ld_rd,
   input  logic [31:0] ld_data,
   input  logic        pend_set,
   input  logic [4:0]  pend_rd,
   output logic [31:0] busy_mask,
   output logic [4:0]  rf_rw,
   output logic [31:0] rf_bus_w,
   output logic        rf_we,
   input  logic [4:0]  ra,
   input  logic [4:0]  rb,
   input  logic [31:0] rf_bus_a,
   input  logic [31:0] rf_bus_b,
   output logic [31:0] opnd_a,
   output logic [31:0] opnd_b
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_entry_t;

   typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_BUF, SRC_LD} src_e;

   wb_entry_t     buf_q [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_nxt;
   logic [SW-1:0] starve, starve_nxt;
   logic          rf_ld;
   src_e          src;
   wb_entry_t     commit;
   logic          buf_empty, ld_acc, push, pop, stall_nxt, we_nxt;
   logic [31:0]   busy_nxt;

   always_comb begin
      buf_empty = (count == '0);
      ld_acc    = ld_valid & ld_ready;
      src       = SRC_NONE;
      if (alu_stall && !buf_empty)      src = SRC_BUF;
      else if (alu_valid && !alu_stall) src = SRC_ALU;
      else if (!buf_empty)              src = SRC_BUF;
      else if (ld_acc)                  src = SRC_LD;
      pop  = (src == SRC_BUF);
      // a load that does not go straight to the port must queue behind the winner
      push = ld_acc && (src != SRC_LD);
      case (src)
         SRC_ALU: commit = '{rd: alu_rd, data: alu_data};
         SRC_BUF: commit = buf_q[rd_ptr];
         SRC_LD:  commit = '{rd: ld_rd, data: ld_data};
         default: commit = '0;
      endcase
      we_nxt    = (src != SRC_NONE) && (commit.rd != 5'd0);
      count_nxt = count + CW'(push) - CW'(pop);
      if (buf_empty || pop)     starve_nxt = '0;
      else if (src == SRC_ALU)  starve_nxt = starve + SW'(1);
      else                      starve_nxt = starve;
      stall_nxt = (starve_nxt >= SW'(STARVE_MAX));
      // clear follows the port write by a cycle so the RF has absorbed the data
      busy_nxt = busy_mask;
      if (rf_we && rf_ld) busy_nxt[rf_rw] = 1'b0;
      if (pend_set)       busy_nxt[pend_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) buf_q[wr_ptr] <= '{rd: ld_rd, data: ld_data};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         starve    <= '0;
         alu_stall <= 1'b0;
         ld_ready  <= 1'b0;
         busy_mask <= '0;
         rf_we     <= 1'b0;
         rf_rw     <= '0;
         rf_bus_w  <= '0;
         rf_ld     <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count     <= count_nxt;
         starve    <= starve_nxt;
         alu_stall <= stall_nxt;
         ld_ready  <= (count_nxt < CW'(DEPTH));
         busy_mask <= busy_nxt;
         rf_we     <= we_nxt;
         rf_ld     <= (src == SRC_BUF) || (src == SRC_LD);
         if (we_nxt) begin
            rf_rw    <= commit.rd;
            rf_bus_w <= commit.data;
         end
      end
   end

`ifdef WB_FORWARD_EN
   assign opnd_a = (rf_we && (rf_rw == ra) && (ra != 5'd0)) ? rf_bus_w : rf_bus_a;
   assign opnd_b = (rf_we && (rf_rw == rb) && (rb != 5'd0)) ? rf_bus_w : rf_bus_b;
`else
   logic unused_rd_addr;
   assign unused_rd_addr = ^{ra, rb};
   assign opnd_a = rf_bus_a;
   assign opnd_b = rf_bus_b;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_writeback_unit;
   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;
`ifdef WB_FORWARD_EN
   localparam logic [31:0] EXP_FWD_A = 32'hDEADBEEF;
`else
   localparam logic [31:0] EXP_FWD_A = 32'h11111111;
`endif

   logic        clk, rst;
   logic        alu_valid, alu_stall, ld_valid, ld_ready, pend_set, rf_we;
   logic [4:0]  alu_rd, ld_rd, pend_rd, rf_rw, ra, rb;
   logic [31:0] alu_data, ld_data, busy_mask, rf_bus_w, rf_bus_a, rf_bus_b, opnd_a, opnd_b;

   writeback_unit #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .pend_set(pend_set), .pend_rd(pend_rd), .busy_mask(busy_mask),
      .rf_rw(rf_rw), .rf_bus_w(rf_bus_w), .rf_we(rf_we),
      .ra(ra), .rb(rb), .rf_bus_a(rf_bus_a), .rf_bus_b(rf_bus_b),
      .opnd_a(opnd_a), .opnd_b(opnd_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0, n_pass = 0, n_proto = 0;

   // reference model state
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] d;
   } ld_t;
   ld_t         mq[$];
   int          mstarve = 0;
   bit          mstall = 0, mready = 0, mwe = 0, mld = 0;
   logic [4:0]  mrw = '0;
   logic [31:0] mdata = '0, mbusy = '0;

   task automatic model_edge();
      ld_t e, p;
      bit was_empty;
      int src;
      logic [31:0] nb;
      if (!rst) begin
         mq.delete(); mstarve = 0; mstall = 0; mready = 0;
         mbusy = '0; mwe = 0; mld = 0; mrw = '0; mdata = '0;
      end else begin
         was_empty = (mq.size() == 0);
         nb = mbusy;
         if (mwe && mld) nb[mrw] = 1'b0;
         if (pend_set) nb[pend_rd] = 1'b1;
         nb[0] = 1'b0;
         mbusy = nb;
         if (mstall && !was_empty)         src = 2;
         else if (alu_valid && !mstall)    src = 1;
         else if (!was_empty)              src = 2;
         else if (ld_valid && mready)      src = 3;
         else                              src = 0;
         e.rd = '0; e.d = '0;
         if (src == 1) begin e.rd = alu_rd; e.d = alu_data; end
         if (src == 2) e = mq.pop_front();
         if (src == 3) begin e.rd = ld_rd; e.d = ld_data; end
         if (ld_valid && mready && src != 3) begin
            p.rd = ld_rd; p.d = ld_data; mq.push_back(p);
         end
         if (was_empty || src == 2) mstarve = 0;
         else if (src == 1)         mstarve++;
         mstall = (mstarve >= STARVE_MAX);
         mready = (mq.size() < DEPTH);
         mwe = (src != 0) && (e.rd != 5'd0);
         mld = (src >= 2);
         if (mwe) begin mrw = e.rd; mdata = e.d; end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      alu_valid = 0; ld_valid = 0; pend_set = 0;
   endtask

   task automatic do_reset();
      idle(); rst = 0; step(); step(); rst = 1; step();
   endtask

   // protocol monitor: upstream obligations
   always @(posedge clk) begin
      if (rst === 1'b1 && alu_valid === 1'b1 && alu_stall === 1'b1) begin
         n_proto++;
         $display("FAIL protocol alu_valid during stall: got alu_valid=1, required 0");
      end
      if (rst === 1'b1 && pend_set === 1'b1 && busy_mask[pend_rd] === 1'b1) begin
         n_proto++;
         $display("FAIL protocol pend_set on busy r%0d: got busy=1, required 0", pend_rd);
      end
   end

   task automatic test_reset();
      idle(); rst = 0; step();
      n_checks++;
      if ({rf_we, rf_rw, rf_bus_w, busy_mask, alu_stall, ld_ready} !== '0)
         $display("FAIL reset_outputs: got %0h, required 0",
                  {rf_we, rf_rw, rf_bus_w, busy_mask, alu_stall, ld_ready});
      else n_pass++;
      rst = 1; step();
      n_checks++;
      if (ld_ready !== 1'b1) $display("FAIL reset_ld_ready: got %0b, required 1", ld_ready);
      else n_pass++;
   endtask

   task automatic test_alu_only();
      do_reset();
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
      step(); idle();
      n_checks++;
      if ({rf_we, rf_rw, rf_bus_w} !== {1'b1, 5'd5, 32'hDEADBEEF})
         $display("FAIL alu_only: got we=%0b rw=%0d w=%h, required 1/5/deadbeef", rf_we, rf_rw, rf_bus_w);
      else n_pass++;
      step();
      n_checks++;
      if (rf_we !== 1'b0) $display("FAIL alu_only_idle: got we=%0b, required 0", rf_we);
      else n_pass++;
   endtask

   task automatic test_collision();
      do_reset();
      pend_set = 1; pend_rd = 7; step(); pend_set = 0;
      alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
      ld_valid = 1; ld_rd = 7; ld_data = 32'h22;
      step(); idle();
      n_checks++;
      if ({rf_we, rf_rw, rf_bus_w, busy_mask[7]} !== {1'b1, 5'd3, 32'h11, 1'b1})
         $display("FAIL collision_n1: got we=%0b rw=%0d w=%h busy7=%0b, required 1/3/11/1",
                  rf_we, rf_rw, rf_bus_w, busy_mask[7]);
      else n_pass++;
      step();
      n_checks++;
      if ({rf_we, rf_rw, rf_bus_w, busy_mask[7]} !== {1'b1, 5'd7, 32'h22, 1'b1})
         $display("FAIL collision_n2: got we=%0b rw=%0d w=%h busy7=%0b, required 1/7/22/1",
                  rf_we, rf_rw, rf_bus_w, busy_mask[7]);
      else n_pass++;
      step();
      n_checks++;
      if ({rf_we, busy_mask[7]} !== 2'b00)
         $display("FAIL collision_n3: got we=%0b busy7=%0b, required 0/0", rf_we, busy_mask[7]);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int li = 0, nlog = 0;
      bit acc;
      logic [4:0]  log_rd[4];
      logic [31:0] log_d[4];
      do_reset();
      for (int c = 0; c < 24; c++) begin
         alu_valid = (c < 16) && !alu_stall; alu_rd = 1; alu_data = c;
         ld_valid = (li < 3); ld_rd = 5'(10 + li); ld_data = 32'hA0 + li;
         acc = ld_valid && ld_ready;
         step();
         if (acc) li++;
         if (c == 1) begin
            n_checks++;
            if (ld_ready !== 1'b0) $display("FAIL bp_ready_low: got %0b, required 0", ld_ready);
            else n_pass++;
         end
         if (c == 4) begin
            n_checks++;
            if ({alu_stall, 2'(li)} !== {1'b1, 2'd2})
               $display("FAIL bp_stall: got stall=%0b accepted=%0d, required 1/2", alu_stall, li);
            else n_pass++;
         end
         if (c == 5) begin
            n_checks++;
            if ({rf_we, rf_rw, rf_bus_w} !== {1'b1, 5'd10, 32'hA0})
               $display("FAIL bp_drain: got we=%0b rw=%0d w=%h, required 1/10/a0", rf_we, rf_rw, rf_bus_w);
            else n_pass++;
         end
         if (rf_we && rf_rw >= 10 && rf_rw <= 12 && nlog < 4) begin
            log_rd[nlog] = rf_rw; log_d[nlog] = rf_bus_w; nlog++;
         end
      end
      idle();
      n_checks++;
      if (nlog != 3) $display("FAIL bp_count: got %0d load commits, required 3", nlog);
      else n_pass++;
      for (int i = 0; i < 3 && i < nlog; i++) begin
         n_checks++;
         if ({log_rd[i], log_d[i]} !== {5'(10 + i), 32'hA0 + i})
            $display("FAIL bp_order[%0d]: got rd=%0d d=%h, required rd=%0d d=%h",
                     i, log_rd[i], log_d[i], 10 + i, 32'hA0 + i);
         else n_pass++;
      end
   endtask

   task automatic test_reg0();
      do_reset();
      alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
      ld_valid = 1; ld_rd = 0; ld_data = 32'h66;
      pend_set = 1; pend_rd = 0;
      step(); idle();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({rf_we, busy_mask} !== 33'd0)
            $display("FAIL reg0[%0d]: got we=%0b busy=%h, required 0/0", i, rf_we, busy_mask);
         else n_pass++;
         step();
      end
   endtask

   task automatic test_scoreboard();
      do_reset();
      pend_set = 1; pend_rd = 9; step(); pend_set = 0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (busy_mask !== 32'h200) $display("FAIL sb_held[%0d]: got %h, required 200", i, busy_mask);
         else n_pass++;
         step();
      end
      ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
      step(); idle();
      n_checks++;
      if ({rf_we, rf_rw, rf_bus_w, busy_mask} !== {1'b1, 5'd9, 32'h99, 32'h200})
         $display("FAIL sb_commit: got we=%0b rw=%0d w=%h busy=%h, required 1/9/99/200",
                  rf_we, rf_rw, rf_bus_w, busy_mask);
      else n_pass++;
      step();
      n_checks++;
      if (busy_mask !== 32'h0) $display("FAIL sb_clear: got %h, required 0", busy_mask);
      else n_pass++;
   endtask

   task automatic test_reset_midflight();
      do_reset();
      pend_set = 1; pend_rd = 20;
      for (int c = 0; c < 3; c++) begin
         alu_valid = 1; alu_rd = 2; alu_data = c;
         ld_valid = (c < 2); ld_rd = 5'(21 + c); ld_data = 32'hB0 + c;
         step(); pend_set = 0;
      end
      idle(); rst = 0; step();
      n_checks++;
      if ({rf_we, rf_rw, rf_bus_w, busy_mask, alu_stall, ld_ready} !== '0)
         $display("FAIL midreset_outputs: got %0h, required 0",
                  {rf_we, rf_rw, rf_bus_w, busy_mask, alu_stall, ld_ready});
      else n_pass++;
      rst = 1; step();
      n_checks++;
      if ({rf_we, ld_ready} !== 2'b01) $display("FAIL midreset_rel: got we=%0b ready=%0b, required 0/1", rf_we, ld_ready);
      else n_pass++;
      step();
      n_checks++;
      if ({rf_we, busy_mask} !== 33'd0) $display("FAIL midreset_empty: got we=%0b busy=%h, required 0/0", rf_we, busy_mask);
      else n_pass++;
   endtask

   task automatic test_forward();
      do_reset();
      ra = 5; rb = 7; rf_bus_a = 32'h11111111; rf_bus_b = 32'h22222222;
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
      step(); idle(); #1;
      n_checks++;
      if ({opnd_a, opnd_b} !== {EXP_FWD_A, 32'h22222222})
         $display("FAIL fwd_commit: got a=%h b=%h, required a=%h b=22222222", opnd_a, opnd_b, EXP_FWD_A);
      else n_pass++;
      step(); #1;
      n_checks++;
      if (opnd_a !== 32'h11111111) $display("FAIL fwd_idle: got a=%h, required 11111111", opnd_a);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [4:0] lq[$];
      bit [31:0] outst = '0;
      bit acc;
      int r;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(63) == 0) begin
            rst = 0; idle(); lq.delete(); outst = '0;
         end else begin
            rst = 1;
            alu_rd = 5'($urandom_range(31)); alu_data = $urandom;
            alu_valid = !mstall && ($urandom_range(1) == 1) && !mbusy[alu_rd] && !outst[alu_rd];
            r = $urandom_range(31, 1);
            pend_set = ($urandom_range(2) == 0) && !mbusy[r] && !outst[r];
            pend_rd = 5'(r);
            if (!ld_valid && lq.size() > 0 && $urandom_range(1) == 1) begin
               ld_valid = 1; ld_rd = lq.pop_front(); ld_data = $urandom;
            end
         end
         acc = rst && ld_valid && mready;
         step();
         if (rst && pend_set) begin outst[pend_rd] = 1; lq.push_back(pend_rd); end
         if (acc) begin outst[ld_rd] = 0; ld_valid = 0; end
         n_checks++;
         if (rf_we !== mwe) $display("FAIL rand_we cyc %0d: got %0b, required %0b", c, rf_we, mwe);
         else n_pass++;
         if (mwe) begin
            n_checks++;
            if ({rf_rw, rf_bus_w} !== {mrw, mdata})
               $display("FAIL rand_wdata cyc %0d: got rw=%0d w=%h, required rw=%0d w=%h", c, rf_rw, rf_bus_w, mrw, mdata);
            else n_pass++;
         end
         n_checks++;
         if (busy_mask !== mbusy) $display("FAIL rand_busy cyc %0d: got %h, required %h", c, busy_mask, mbusy);
         else n_pass++;
         n_checks++;
         if ({alu_stall, ld_ready} !== {mstall, mready})
            $display("FAIL rand_flow cyc %0d: got stall=%0b ready=%0b, required %0b/%0b",
                     c, alu_stall, ld_ready, mstall, mready);
         else n_pass++;
      end
      idle(); rst = 1;
   endtask

   initial begin
      rst = 0; alu_valid = 0; alu_rd = 0; alu_data = 0;
      ld_valid = 0; ld_rd = 0; ld_data = 0; pend_set = 0; pend_rd = 0;
      ra = 0; rb = 0; rf_bus_a = 0; rf_bus_b = 0;
      test_reset();
      test_alu_only();
      test_collision();
      test_backpressure();
      test_reg0();
      test_scoreboard();
      test_reset_midflight();
      test_forward();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks + n_proto);
      $finish;
   end
endmodule
